// File: rtl/demux_sipo.sv
// rtl/demux_sipo.sv - serial-to-parallel two-channel demultiplexer with per-channel word handshake
// Optional DEMUX_PARITY_EN: each word takes an extra even-parity bit and flags x_perr/y_perr.

module demux_sipo_chan #(
  parameter int WIDTH = 4,
  parameter int NBITS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic             bit_in,
  input  logic             ready,
  output logic             valid,
`ifdef DEMUX_PARITY_EN
  output logic             perr,
`endif
  output logic [WIDTH-1:0] word
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
`ifdef DEMUX_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef DEMUX_PARITY_EN
    par_d   = par_q;
`endif
    // Pop first so a same-cycle push lands as bit 0 of a fresh word.
    if (state_q == FULL && ready) begin
      state_d = FILL;
      cnt_d   = '0;
    end
    if (acc) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (cnt_d == CW'(b)) word_d[b] = bit_in;
      end
`ifdef DEMUX_PARITY_EN
      par_d = ((cnt_d == '0) ? 1'b0 : par_q) ^ bit_in;
`endif
      if (cnt_d == CW'(NBITS - 1)) state_d = FULL;
      cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef DEMUX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef DEMUX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign valid = (state_q == FULL);
  assign word  = word_q;
`ifdef DEMUX_PARITY_EN
  assign perr  = par_q;
`endif

endmodule

module demux_sipo #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_sel,
  input  logic             in_inv,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] x_word,
`ifdef DEMUX_PARITY_EN
  output logic             x_perr,
  output logic             y_perr,
`endif
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_word
);

`ifdef DEMUX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic stored_bit;
  logic acc_x, acc_y;

  assign in_ready   = in_sel ? (!y_valid || y_ready) : (!x_valid || x_ready);
  assign stored_bit = in_bit ^ in_inv;
  assign acc_x      = in_valid && in_ready && !in_sel;
  assign acc_y      = in_valid && in_ready &&  in_sel;

  demux_sipo_chan #(.WIDTH(WIDTH), .NBITS(NBITS)) u_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc    (acc_x),
    .bit_in (stored_bit),
    .ready  (x_ready),
    .valid  (x_valid),
`ifdef DEMUX_PARITY_EN
    .perr   (x_perr),
`endif
    .word   (x_word)
  );

  demux_sipo_chan #(.WIDTH(WIDTH), .NBITS(NBITS)) u_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc    (acc_y),
    .bit_in (stored_bit),
    .ready  (y_ready),
    .valid  (y_valid),
`ifdef DEMUX_PARITY_EN
    .perr   (y_perr),
`endif
    .word   (y_word)
  );

endmodule

// File: tb/tb_demux_sipo.sv
// tb/tb_demux_sipo.sv - directed plus randomized checks of demux_sipo against a word-level model
module tb_demux_sipo;

  localparam int WIDTH = 4;
`ifdef DEMUX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_sel = 1'b0, in_inv = 1'b0;
  logic in_ready;
  logic x_valid, y_valid;
  logic x_ready = 1'b0, y_ready = 1'b0;
  logic [WIDTH-1:0] x_word, y_word;
`ifdef DEMUX_PARITY_EN
  logic x_perr, y_perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_sipo #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .in_sel   (in_sel),
    .in_inv   (in_inv),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_word   (x_word),
`ifdef DEMUX_PARITY_EN
    .x_perr   (x_perr),
    .y_perr   (y_perr),
`endif
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_word   (y_word)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send_bit(input logic s, input logic b, input logic inv);
    @(negedge clk);
    in_valid = 1'b1; in_sel = s; in_bit = b; in_inv = inv;
    #1;
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_rdy: got in_ready 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends WIDTH bits LSB-first and, with parity enabled, the even-parity bit (optionally corrupted).
  task automatic send_word(input logic s, input logic inv, input logic [WIDTH-1:0] w, input logic bad_par);
    for (int i = 0; i < WIDTH; i++) send_bit(s, w[i] ^ inv, inv);
`ifdef DEMUX_PARITY_EN
    send_bit(s, (^w) ^ bad_par ^ inv, inv);
`else
    if (bad_par) $display("note: parity disabled");
`endif
  endtask

  task automatic pop(input logic s);
    @(negedge clk);
    if (s) y_ready = 1'b1; else x_ready = 1'b1;
    @(posedge clk);
    #1;
    x_ready = 1'b0; y_ready = 1'b0;
  endtask

  // Word-level reference: bits collected per channel, word frozen when NBITS are in.
  int               m_cnt[2];
  logic [WIDTH-1:0] m_asm[2];
  logic             m_par[2];
  logic             m_full[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_asm[c] = '0; m_par[c] = 1'b0; m_full[c] = 1'b0;
    end
  endtask

  task automatic random_phase(input int cycles);
    logic rdy_c[2];
    logic exp_rdy, accept, b;
    int   c;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      in_sel   = 1'($urandom);
      in_bit   = 1'($urandom);
      in_inv   = 1'($urandom);
      x_ready  = 1'($urandom);
      y_ready  = 1'($urandom);
      #1;
      rdy_c[0] = x_ready; rdy_c[1] = y_ready;
      c = int'(in_sel);
      exp_rdy = !m_full[c] || rdy_c[c];
      check("r_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("r_x_valid", 32'(x_valid), 32'(m_full[0]));
      check("r_y_valid", 32'(y_valid), 32'(m_full[1]));
      if (m_full[0]) check("r_x_word", 32'(x_word), 32'(m_asm[0]));
      if (m_full[1]) check("r_y_word", 32'(y_word), 32'(m_asm[1]));
`ifdef DEMUX_PARITY_EN
      if (m_full[0]) check("r_x_perr", 32'(x_perr), 32'(m_par[0]));
      if (m_full[1]) check("r_y_perr", 32'(y_perr), 32'(m_par[1]));
`endif
      accept = in_valid && exp_rdy;
      b = in_bit ^ in_inv;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (m_full[k] && rdy_c[k]) begin
          m_full[k] = 1'b0; m_cnt[k] = 0; m_par[k] = 1'b0;
        end
      end
      if (accept) begin
        if (m_cnt[c] < WIDTH) m_asm[c][m_cnt[c]] = b;
        m_par[c] = m_par[c] ^ b;
        m_cnt[c]++;
        if (m_cnt[c] == NBITS) m_full[c] = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; x_ready = 1'b0; y_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_x_word", 32'(x_word), 32'd0);
    check("rst_y_word", 32'(y_word), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic fill on x: bits 1,0,1,1
    send_word(1'b0, 1'b0, 4'b1101, 1'b0);
    check("fill_x_valid", 32'(x_valid), 32'd1);
    check("fill_x_word", 32'(x_word), 32'hd);
    check("fill_y_valid", 32'(y_valid), 32'd0);

    // Backpressure on x while y stays open
    @(negedge clk);
    in_sel = 1'b0; #1;
    check("bp_rdy_x", 32'(in_ready), 32'd0);
    in_sel = 1'b1; #1;
    check("bp_rdy_y", 32'(in_ready), 32'd1);

    // Inversion on y: raw bits 1,0,1,1 with inv -> 4'b0010
    send_word(1'b1, 1'b1, 4'b0010, 1'b0);
    check("inv_y_valid", 32'(y_valid), 32'd1);
    check("inv_y_word", 32'(y_word), 32'h2);
    check("hold_x_word", 32'(x_word), 32'hd);
    pop(1'b1);
    check("pop_y_valid", 32'(y_valid), 32'd0);

    // Simultaneous pop and push on x
    @(negedge clk);
    x_ready = 1'b1;
    send_bit(1'b0, 1'b1, 1'b0);
    x_ready = 1'b0;
    check("pp_x_valid", 32'(x_valid), 32'd0);
    check("pp_x_bit0", 32'(x_word[0]), 32'd1);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
`ifdef DEMUX_PARITY_EN
    send_bit(1'b0, 1'b0, 1'b0);
`endif
    check("pp_x_valid2", 32'(x_valid), 32'd1);
    check("pp_x_word", 32'(x_word), 32'h9);
    pop(1'b0);

    // Interleaved x/y words
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(1'b0, (i % 2) == 0, 1'b0);
      send_bit(1'b1, i >= 2, 1'b0);
    end
`ifdef DEMUX_PARITY_EN
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
`endif
    check("il_x_word", 32'(x_word), 32'h5);
    check("il_y_word", 32'(y_word), 32'hc);
    pop(1'b0);
    pop(1'b1);

    // Reset mid-fill discards the partial word
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("mrst_x_valid", 32'(x_valid), 32'd0);
    check("mrst_x_word", 32'(x_word), 32'd0);
    rst_n = 1'b1;
    send_word(1'b0, 1'b0, 4'b1111, 1'b0);
    check("mrst_x_word2", 32'(x_word), 32'hf);
    pop(1'b0);

`ifdef DEMUX_PARITY_EN
    send_word(1'b0, 1'b0, 4'b1101, 1'b0);
    check("par_ok_word", 32'(x_word), 32'hd);
    check("par_ok_perr", 32'(x_perr), 32'd0);
    pop(1'b0);
    send_word(1'b0, 1'b0, 4'b1101, 1'b1);
    check("par_bad_perr", 32'(x_perr), 32'd1);
    pop(1'b0);
`endif

    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    random_phase(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
